// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader : streams a length-prefixed, checksummed program into the
//               instruction memory and holds the CPU until the image verifies.
// Revision    : 1.0
// ============================================================================
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [ADDR_W:0] WORD_ONE  = (ADDR_W + 1)'(1);
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       len_q, len_nxt;
  logic [7:0]        hi_q, hi_nxt;
  logic [7:0]        chk_q, chk_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic              mem_we_nxt, cpu_hold_nxt, busy_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [15:0]       mem_wdata_nxt;
  logic [ADDR_W:0]   words_nxt;
  logic              xfer, go_err, last_word;
  logic [15:0]       len_full;

  assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                     (state == S_DATA_LO) || (state == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign len_full  = {len_q[15:8], in_data};
  assign last_word = (16'(words_loaded) + 16'd1) == len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    hi_nxt        = hi_q;
    chk_nxt       = chk_q;
    to_nxt        = to_cnt;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_hold_nxt  = cpu_hold;
    busy_nxt      = busy;
    done_nxt      = done;
    err_nxt       = err;
    words_nxt     = words_loaded;
    go_err        = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt    = S_LEN_HI;
          chk_nxt      = 8'h00;
          words_nxt    = '0;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          cpu_hold_nxt = 1'b1;
          busy_nxt     = 1'b1;
          to_nxt       = '0;
        end
      end
      S_LEN_HI: if (xfer) begin
        len_nxt[15:8] = in_data;
        chk_nxt       = chk_q ^ in_data;
        state_nxt     = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_nxt[7:0] = in_data;
        chk_nxt      = chk_q ^ in_data;
        // Longer images than the memory holds would wrap and overwrite word 0.
        if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS)) go_err = 1'b1;
        else                                                       state_nxt = S_DATA_HI;
      end
      S_DATA_HI: if (xfer) begin
        hi_nxt    = in_data;
        chk_nxt   = chk_q ^ in_data;
        state_nxt = S_DATA_LO;
      end
      S_DATA_LO: if (xfer) begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = words_loaded[ADDR_W-1:0];
        mem_wdata_nxt = {hi_q, in_data};
        words_nxt     = words_loaded + WORD_ONE;
        chk_nxt       = chk_q ^ in_data;
        state_nxt     = last_word ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (xfer) begin
        if (in_data == chk_q) begin
          state_nxt    = S_DONE;
          cpu_hold_nxt = 1'b0;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
        end else begin
          go_err = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (in_ready) begin
      if (xfer)                  to_nxt = '0;
      else if (to_cnt == TO_LAST) go_err = 1'b1;
      else                       to_nxt = to_cnt + TO_ONE;
    end

    if (go_err) begin
      state_nxt    = S_ERR;
      cpu_hold_nxt = 1'b1;
      err_nxt      = 1'b1;
      done_nxt     = 1'b0;
      busy_nxt     = 1'b0;
      to_nxt       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q        <= 16'h0000;
      hi_q         <= 8'h00;
      chk_q        <= 8'h00;
      to_cnt       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 16'h0000;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      len_q        <= len_nxt;
      hi_q         <= hi_nxt;
      chk_q        <= chk_nxt;
      to_cnt       <= to_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      cpu_hold     <= cpu_hold_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      words_loaded <= words_nxt;
    end
  end

endmodule
`default_nettype wire
